// File: rtl/ysyx_23060332_seq_ctrl.sv
// Multi-cycle IF->EX->(LS)->WB sequencer that owns the shared memory port for the ysyx_23060332 core.
// Optional memory watchdog enabled by defining YSYX_23060332_CTRL_TIMEOUT_EN.
module ysyx_23060332_seq_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic              halt_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [3:0]        ls_wmask_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              reg_commit_o,
  output logic              pc_wen_o,
  output logic [63:0]       instret_o,
  output logic              halted_o,
  output logic              error_o
);

  typedef enum logic [3:0] {
    IDLE, IF_REQ, IF_WAIT, EX, LS_REQ, LS_WAIT, WB, HALT, ERR
  } state_t;

  state_t state, next_state;
  logic   ls_load;
  logic   unused_bits;

  // PC low bits are always forced to word alignment; the watchdog limit is only read with the macro.
  assign unused_bits = ^{pc_i[1:0], TIMEOUT_CYCLES};

`ifdef YSYX_23060332_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            in_txn;
  logic            to_hit;

  assign in_txn = (state == IF_REQ) || (state == IF_WAIT) ||
                  (state == LS_REQ) || (state == LS_WAIT);
  assign to_hit = in_txn && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if ((next_state == IF_REQ || next_state == LS_REQ) && next_state != state) begin
      to_cnt <= '0;
    end else if (in_txn) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) error_o <= 1'b0;
    else if (next_state == ERR) error_o <= 1'b1;
  end
`else
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IF_REQ;
      IF_REQ:  if (mem_gnt_i) next_state = IF_WAIT;
      IF_WAIT: if (mem_rvalid_i) next_state = EX;
      EX: begin
        if (halt_i)                      next_state = HALT;
        else if (is_load_i || is_store_i) next_state = LS_REQ;
        else                             next_state = WB;
      end
      LS_REQ:  if (mem_gnt_i) next_state = LS_WAIT;
      LS_WAIT: if (mem_rvalid_i) next_state = WB;
      WB:      next_state = IF_REQ;
      HALT:    next_state = HALT;
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
`ifdef YSYX_23060332_CTRL_TIMEOUT_EN
    if (to_hit) next_state = ERR;
`endif
  end

  // Request fields are pure decodes of the registered state, so they hold until gnt.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = 4'b0000;
    case (state)
      IF_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {pc_i[ADDR_W-1:2], 2'b00};
      end
      LS_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = is_store_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
        mem_wmask_o = is_store_i ? ls_wmask_i : 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_o      <= '0;
      load_data_o <= '0;
      ls_load     <= 1'b0;
    end else begin
      if (state == IF_WAIT && mem_rvalid_i) inst_o <= mem_rdata_i;
      if (state == EX) ls_load <= is_load_i && !is_store_i;
      if (state == LS_WAIT && mem_rvalid_i && ls_load) load_data_o <= mem_rdata_i;
    end
  end

  // Retire strobes are flops loaded from the next-state decode: glitch-free and high only in WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_commit_o <= 1'b0;
      pc_wen_o     <= 1'b0;
      instret_o    <= 64'd0;
      halted_o     <= 1'b0;
    end else begin
      reg_commit_o <= (next_state == WB);
      pc_wen_o     <= (next_state == WB);
      if (next_state == WB) instret_o <= instret_o + 64'd1;
      if (next_state == HALT) halted_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_seq_ctrl.sv
// Directed bench for ysyx_23060332_seq_ctrl: fetch, load, store, halt, spurious rvalid, reset, watchdog.
module tb_ysyx_23060332_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = 32'h8000_0006;
  logic        is_load_i = 1'b0, is_store_i = 1'b0, halt_i = 1'b0;
  logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
  logic [3:0]  ls_wmask_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] inst_o, load_data_o;
  logic        reg_commit_o, pc_wen_o, halted_o, error_o;
  logic [63:0] instret_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060332_seq_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .halt_i(halt_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .inst_o(inst_o),
    .load_data_o(load_data_o), .reg_commit_o(reg_commit_o), .pc_wen_o(pc_wen_o),
    .instret_o(instret_o), .halted_o(halted_o), .error_o(error_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one fetch handshake from IF_REQ; leaves the DUT in EX.
  task automatic do_fetch(input logic [31:0] word);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = word;
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_cmp++;
    if ({mem_req_o, mem_we_o, reg_commit_o, pc_wen_o, halted_o, error_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {mem_req_o, mem_we_o, reg_commit_o, pc_wen_o, halted_o, error_o});
    end
    n_cmp++;
    if ({inst_o, load_data_o, instret_o, mem_addr_o, mem_wdata_o, mem_wmask_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: inst %h ld %h instret %0d addr %h wdata %h mask %b want all 0",
               inst_o, load_data_o, instret_o, mem_addr_o, mem_wdata_o, mem_wmask_o);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_alu();
    // cycle 0 after release: IDLE
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_bad++; $display("FAIL alu_idle_req: got %b want 0", mem_req_o);
    end
    tick(); // cycle 1: IF_REQ
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o} !== {2'b10, 32'h8000_0004, 4'b0000}) begin
      n_bad++;
      $display("FAIL alu_ifreq: req %b we %b addr %h mask %b want 1 0 80000004 0000",
               mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o);
    end
    do_fetch(32'h0000_0013); // cycle 3: EX
    n_cmp++;
    if (inst_o !== 32'h0000_0013 || reg_commit_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_ex: inst %h commit %b req %b want 00000013 0 0", inst_o, reg_commit_o, mem_req_o);
    end
    tick(); // cycle 4: WB
    n_cmp++;
    if ({reg_commit_o, pc_wen_o} !== 2'b11 || instret_o !== 64'd1) begin
      n_bad++;
      $display("FAIL alu_wb: commit %b pc_wen %b instret %0d want 1 1 1", reg_commit_o, pc_wen_o, instret_o);
    end
    tick(); // back to IF_REQ
    n_cmp++;
    if ({reg_commit_o, pc_wen_o, mem_req_o} !== 3'b001 || instret_o !== 64'd1) begin
      n_bad++;
      $display("FAIL alu_after_wb: commit %b pc_wen %b req %b instret %0d want 0 0 1 1",
               reg_commit_o, pc_wen_o, mem_req_o, instret_o);
    end
  endtask

  task automatic test_load();
    do_fetch(32'h0000_2083); // IF_REQ@1, EX@3
    is_load_i  = 1'b1;
    ls_addr_i  = 32'h8000_0010;
    ls_wdata_i = 32'h5555_5555;
    ls_wmask_i = 4'b1111;
    tick(); // LS_REQ@4
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o} !== {2'b10, 32'h8000_0010, 4'b0000}) begin
      n_bad++;
      $display("FAIL load_req: req %b we %b addr %h mask %b want 1 0 80000010 0000",
               mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o);
    end
    mem_gnt_i = 1'b1;
    tick(); // LS_WAIT@5
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    tick(); // WB@6
    mem_rvalid_i = 1'b0;
    is_load_i    = 1'b0;
    n_cmp++;
    if (load_data_o !== 32'hDEAD_BEEF || reg_commit_o !== 1'b1 || instret_o !== 64'd2) begin
      n_bad++;
      $display("FAIL load_wb: ld %h commit %b instret %0d want deadbeef 1 2",
               load_data_o, reg_commit_o, instret_o);
    end
    tick();
  endtask

  task automatic test_store_delayed_gnt();
    int stable_bad = 0;
    do_fetch(32'h0020_a023);
    is_store_i = 1'b1;
    ls_addr_i  = 32'h8000_0020;
    ls_wdata_i = 32'h1234_5678;
    ls_wmask_i = 4'b0011;
    tick(); // LS_REQ
    for (int i = 0; i < 4; i++) begin
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o} !==
          {2'b11, 32'h8000_0020, 32'h1234_5678, 4'b0011}) stable_bad++;
      mem_gnt_i = (i == 3);
      tick();
    end
    mem_gnt_i = 1'b0;
    n_cmp++;
    if (stable_bad !== 0) begin
      n_bad++; $display("FAIL store_stable: unstable cycles %0d want 0", stable_bad);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;
    tick(); // WB
    mem_rvalid_i = 1'b0;
    is_store_i   = 1'b0;
    n_cmp++;
    if (reg_commit_o !== 1'b1 || instret_o !== 64'd3 || load_data_o !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL store_wb: commit %b instret %0d ld %h want 1 3 deadbeef",
               reg_commit_o, instret_o, load_data_o);
    end
    tick();
    n_cmp++;
    if (reg_commit_o !== 1'b0 || instret_o !== 64'd3) begin
      n_bad++; $display("FAIL store_single_wb: commit %b instret %0d want 0 3", reg_commit_o, instret_o);
    end
  endtask

  task automatic test_spurious_rvalid();
    do_fetch(32'h0000_0033); // EX
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0BAD_0BAD;
    tick(); // WB
    n_cmp++;
    if (inst_o !== 32'h0000_0033 || load_data_o !== 32'hDEAD_BEEF || reg_commit_o !== 1'b1) begin
      n_bad++;
      $display("FAIL spurious_ex: inst %h ld %h commit %b want 00000033 deadbeef 1",
               inst_o, load_data_o, reg_commit_o);
    end
    tick(); // IF_REQ with rvalid still high and no gnt
    n_cmp++;
    if (mem_req_o !== 1'b1 || inst_o !== 32'h0000_0033 || instret_o !== 64'd4) begin
      n_bad++;
      $display("FAIL spurious_wb: req %b inst %h instret %0d want 1 00000033 4", mem_req_o, inst_o, instret_o);
    end
    tick(); // still IF_REQ: rvalid must not advance it
    mem_rvalid_i = 1'b0;
    n_cmp++;
    if (mem_req_o !== 1'b1 || reg_commit_o !== 1'b0) begin
      n_bad++; $display("FAIL spurious_ifreq: req %b commit %b want 1 0", mem_req_o, reg_commit_o);
    end
  endtask

  task automatic test_reset_mid_txn();
    mem_gnt_i = 1'b1;
    tick(); // IF_WAIT
    mem_gnt_i = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req_o, reg_commit_o, pc_wen_o} !== 3'b0 || instret_o !== 64'd0 ||
        inst_o !== 32'd0 || load_data_o !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_midtxn: req %b commit %b instret %0d inst %h ld %h want 0 0 0 0 0",
               mem_req_o, reg_commit_o, instret_o, inst_o, load_data_o);
    end
    mem_rvalid_i = 1'b1; // stale response
    mem_rdata_i  = 32'h7777_7777;
    tick();
    rst = 1'b1;
    tick(); // IF_REQ, stale rvalid still high
    tick();
    mem_rvalid_i = 1'b0;
    n_cmp++;
    if (mem_req_o !== 1'b1 || inst_o !== 32'd0 || mem_addr_o !== 32'h8000_0004) begin
      n_bad++;
      $display("FAIL rst_stale: req %b inst %h addr %h want 1 0 80000004", mem_req_o, inst_o, mem_addr_o);
    end
  endtask

  task automatic test_halt();
    int req_seen = 0;
    do_fetch(32'h0010_0073); // EX
    halt_i = 1'b1;
    tick(); // HALT
    halt_i = 1'b0;
    n_cmp++;
    if (halted_o !== 1'b1 || reg_commit_o !== 1'b0 || instret_o !== 64'd0) begin
      n_bad++;
      $display("FAIL halt_enter: halted %b commit %b instret %0d want 1 0 0", halted_o, reg_commit_o, instret_o);
    end
    for (int i = 0; i < 100; i++) begin
      mem_gnt_i    = i[0];
      mem_rvalid_i = ~i[0];
      if (mem_req_o || reg_commit_o || pc_wen_o) req_seen++;
      tick();
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    n_cmp++;
    if (req_seen !== 0 || halted_o !== 1'b1 || instret_o !== 64'd0) begin
      n_bad++;
      $display("FAIL halt_sticky: active cycles %0d halted %b instret %0d want 0 1 0",
               req_seen, halted_o, instret_o);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    tick(); // IF_REQ, cycle 1 of 8
    repeat (7) tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || error_o !== 1'b0) begin
      n_bad++; $display("FAIL timeout_before: req %b err %b want 1 0", mem_req_o, error_o);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b0 || error_o !== 1'b1) begin
      n_bad++; $display("FAIL timeout_hit: req %b err %b want 0 1", mem_req_o, error_o);
    end
    mem_gnt_i = 1'b1;
    repeat (5) tick();
    mem_gnt_i = 1'b0;
    n_cmp++;
    if (mem_req_o !== 1'b0 || error_o !== 1'b1) begin
      n_bad++; $display("FAIL timeout_sticky: req %b err %b want 0 1", mem_req_o, error_o);
    end
  endtask

  task automatic test_no_timeout();
    apply_reset();
    tick();
    repeat (40) tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || error_o !== 1'b0) begin
      n_bad++; $display("FAIL no_timeout: req %b err %b want 1 0", mem_req_o, error_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_delayed_gnt();
    test_spurious_rvalid();
    test_reset_mid_txn();
    test_halt();
`ifdef YSYX_23060332_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
